// File: rtl/audio_dac_i2s_tx_if.sv
// Producer-side sample handshake for the I2S DAC transmitter: one stereo pair per valid/ready transfer.
interface audio_dac_i2s_tx_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] sample_left;
   logic [DATA_WIDTH-1:0] sample_right;
   logic                  sample_valid;
   logic                  sample_ready;

   modport master (output sample_left, output sample_right, output sample_valid, input sample_ready);
   modport slave  (input sample_left, input sample_right, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_dac_i2s_tx.sv
// I2S / left-justified DAC serialiser slaved to codec BCLK/DACLRCK, fed from a one-pair holding buffer.
//
// state    | meaning
// ST_WAIT  | no BCLK fall seen since reset; next fall only records LRCK
// ST_SYNC  | LRCK history valid; first LRCK change locks and starts a channel
// ST_RUN   | locked; every LRCK change starts a channel, other falls shift bits
module audio_dac_i2s_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int I2S_MODE   = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic                 audio_interface_BCLK,
   input  logic                 audio_interface_DACLRCK,
   output logic                 audio_interface_DACDAT,
   audio_dac_i2s_tx_if.slave    smp,
   input  logic                 enable,
   output logic                 frame_start,
   output logic                 underrun,
   output logic [CNT_WIDTH-1:0] underrun_count
);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {ST_WAIT, ST_SYNC, ST_RUN} state_t;

   state_t                state_q;
   logic [2:0]            bclk_s_q;
   logic [1:0]            lrck_s_q;
   logic                  prev_lrck_q;
   logic [DATA_WIDTH-1:0] hold_l_q, hold_r_q, rpend_q, shreg_q;
   logic [BW-1:0]         bitcnt_q;
   logic                  full_q, full_d, ready_q;
   logic                  dacdat_q, frame_start_q, underrun_q;
   logic [CNT_WIDTH-1:0]  cnt_q;

   logic                  bclk_fall, lrck_s, chan_start, left_start, accept, consume;
   logic [DATA_WIDTH-1:0] word_w;

   assign bclk_fall  = ~bclk_s_q[1] & bclk_s_q[2];
   assign lrck_s     = lrck_s_q[1];
   assign chan_start = bclk_fall && (state_q != ST_WAIT) && (lrck_s != prev_lrck_q);
   assign left_start = chan_start && !lrck_s;
   assign accept     = smp.sample_valid && ready_q;
   assign consume    = left_start && full_q && enable;

   // A left start with nothing buffered sends silence; a same-cycle transfer only fills the next frame.
   always_comb begin
      word_w = '0;
      if (left_start) begin
         if (consume) word_w = hold_l_q;
      end else if (enable) begin
         word_w = rpend_q;
      end
   end

   always_comb begin
      full_d = full_q;
      if (consume) full_d = 1'b0;
      if (accept)  full_d = 1'b1;
      if (!enable) full_d = 1'b0;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q       <= ST_WAIT;
         bclk_s_q      <= '0;
         lrck_s_q      <= '0;
         prev_lrck_q   <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         rpend_q       <= '0;
         shreg_q       <= '0;
         bitcnt_q      <= '0;
         full_q        <= 1'b0;
         ready_q       <= 1'b0;
         dacdat_q      <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         cnt_q         <= '0;
      end else begin
         bclk_s_q      <= {bclk_s_q[1:0], audio_interface_BCLK};
         lrck_s_q      <= {lrck_s_q[0], audio_interface_DACLRCK};
         full_q        <= full_d;
         ready_q       <= ~full_d & enable;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         if (accept) begin
            hold_l_q <= smp.sample_left;
            hold_r_q <= smp.sample_right;
         end
         if (bclk_fall) begin
            prev_lrck_q <= lrck_s;
            if (state_q == ST_WAIT) state_q <= ST_SYNC;
            else if (chan_start)    state_q <= ST_RUN;
            if (chan_start) begin
               if (I2S_MODE != 0) begin
                  shreg_q  <= word_w;
                  bitcnt_q <= BW'(DATA_WIDTH);
                  dacdat_q <= 1'b0;
               end else begin
                  shreg_q  <= word_w << 1;
                  bitcnt_q <= BW'(DATA_WIDTH - 1);
                  dacdat_q <= word_w[DATA_WIDTH-1];
               end
               if (left_start) begin
                  frame_start_q <= 1'b1;
                  rpend_q       <= consume ? hold_r_q : '0;
                  if (enable && !full_q) begin
                     underrun_q <= 1'b1;
                     if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
                  end
               end
            end else if (state_q == ST_RUN && bitcnt_q != '0) begin
               dacdat_q <= shreg_q[DATA_WIDTH-1];
               shreg_q  <= shreg_q << 1;
               bitcnt_q <= bitcnt_q - BW'(1);
            end else begin
               dacdat_q <= 1'b0;
            end
         end
      end
   end

   assign audio_interface_DACDAT = dacdat_q;
   assign smp.sample_ready       = ready_q;
   assign frame_start            = frame_start_q;
   assign underrun               = underrun_q;
   assign underrun_count         = cnt_q;
endmodule
